// File: rtl/pwm_duty_capture_pkg.sv
// Shared widths and helpers for the PWM capture path.
package pwm_duty_capture_pkg;

  localparam int unsigned DUTY_W   = 10;
  localparam int unsigned PERIOD_W = 12;

  // Duty per LED segment of the 8-LED bar graph.
  function automatic int unsigned led_step(input int unsigned window);
    return window / 8;
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler producing a one-cycle strobe every TICKS_PER_US clock cycles.
module pwm_tick_gen #(
  parameter int unsigned TICKS_PER_US = 50
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_us
);

  localparam int unsigned CW = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(TICKS_PER_US - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_us = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = tick_us ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_duty_capture.sv
// Measures duty (high samples per window), rising-edge period and stuck-line
// status of an asynchronous PWM input, and drives a thermometer LED bar.
module pwm_duty_capture
  import pwm_duty_capture_pkg::*;
#(
  parameter int unsigned TICKS_PER_US   = 50,
  parameter int unsigned WINDOW         = 1000,
  parameter int unsigned PERIOD_TIMEOUT = 2000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwm_in,
  output logic [DUTY_W-1:0]   duty_data,
  output logic                duty_valid,
  output logic [PERIOD_W-1:0] period_us,
  output logic                period_valid,
  output logic                no_edge,
  output logic [7:0]          led_bar
);

  localparam logic [DUTY_W-1:0]   LastIdx = DUTY_W'(WINDOW - 1);
  localparam logic [PERIOD_W-1:0] Timeout = PERIOD_W'(PERIOD_TIMEOUT);
  localparam int unsigned         Step    = led_step(WINDOW);

  logic tick_us;

  pwm_tick_gen #(
    .TICKS_PER_US(TICKS_PER_US)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .tick_us(tick_us)
  );

  // Two-flop synchronizer plus one history flop for edge detection.
  logic pwm_meta_q, pwm_s_q, pwm_prev_q;
  logic rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_meta_q <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_prev_q <= 1'b0;
    end else begin
      pwm_meta_q <= pwm_in;
      pwm_s_q    <= pwm_meta_q;
      pwm_prev_q <= pwm_s_q;
    end
  end

  assign rise = pwm_s_q & ~pwm_prev_q;

  // Duty window
  logic [DUTY_W-1:0] idx_q, idx_d;
  logic [DUTY_W-1:0] high_q, high_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic              dvalid_q, dvalid_d;
  logic [DUTY_W-1:0] high_inc;

  assign high_inc = high_q + DUTY_W'(pwm_s_q);

  always_comb begin
    idx_d    = idx_q;
    high_d   = high_q;
    duty_d   = duty_q;
    dvalid_d = 1'b0;
    if (tick_us) begin
      if (idx_q == LastIdx) begin
        duty_d   = high_inc;
        dvalid_d = 1'b1;
        high_d   = '0;
        idx_d    = '0;
      end else begin
        high_d = high_inc;
        idx_d  = idx_q + DUTY_W'(1);
      end
    end
  end

  // Period measurement; an edge on a tick cycle drops that tick.
  logic [PERIOD_W-1:0] pcnt_q, pcnt_d;
  logic [PERIOD_W-1:0] pus_q, pus_d;
  logic [PERIOD_W-1:0] pcnt_inc;
  logic                pvalid_q, pvalid_d;
  logic                armed_q, armed_d;
  logic                no_edge_q, no_edge_d;

  assign pcnt_inc = pcnt_q + PERIOD_W'(1);

  always_comb begin
    pcnt_d    = pcnt_q;
    pus_d     = pus_q;
    pvalid_d  = 1'b0;
    armed_d   = armed_q;
    no_edge_d = no_edge_q;
    if (rise) begin
      pcnt_d = '0;
      if (armed_q) begin
        pus_d    = pcnt_q;
        pvalid_d = 1'b1;
      end else begin
        armed_d   = 1'b1;
        no_edge_d = 1'b0;
      end
    end else if (tick_us && (pcnt_q != Timeout)) begin
      pcnt_d = pcnt_inc;
      if (pcnt_inc == Timeout) begin
        no_edge_d = 1'b1;
        armed_d   = 1'b0;
        pus_d     = '0;
      end
    end
  end

  // LED bar follows duty_data one cycle later.
  logic [7:0] led_q, led_d;

  always_comb begin
    led_d = '0;
    for (int i = 0; i < 8; i++) begin
      led_d[i] = (32'(duty_q) >= (32'(i) + 32'd1) * Step);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q     <= '0;
      high_q    <= '0;
      duty_q    <= '0;
      dvalid_q  <= 1'b0;
      pcnt_q    <= '0;
      pus_q     <= '0;
      pvalid_q  <= 1'b0;
      armed_q   <= 1'b0;
      no_edge_q <= 1'b0;
      led_q     <= '0;
    end else begin
      idx_q     <= idx_d;
      high_q    <= high_d;
      duty_q    <= duty_d;
      dvalid_q  <= dvalid_d;
      pcnt_q    <= pcnt_d;
      pus_q     <= pus_d;
      pvalid_q  <= pvalid_d;
      armed_q   <= armed_d;
      no_edge_q <= no_edge_d;
      led_q     <= led_d;
    end
  end

  assign duty_data    = duty_q;
  assign duty_valid   = dvalid_q;
  assign period_us    = pus_q;
  assign period_valid = pvalid_q;
  assign no_edge      = no_edge_q;
  assign led_bar      = led_q;

endmodule

// File: tb/tb_pwm_duty_capture.sv
// Bench for pwm_duty_capture: two parameterisations share one PWM stimulus and
// are checked every cycle against an arithmetic model of the measurement rules.
module tb_pwm_duty_capture;

  localparam int T0 = 1, W0 = 1000, TO0 = 2000;
  localparam int T1 = 3, W1 = 24, TO1 = 60;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       pwm_in = 1'b0;
  logic [9:0]  dd [2];
  logic        dv [2];
  logic [11:0] pu [2];
  logic        pv [2];
  logic        ne [2];
  logic [7:0]  lb [2];

  always #5 clk = ~clk;

  pwm_duty_capture #(
    .TICKS_PER_US(T0), .WINDOW(W0), .PERIOD_TIMEOUT(TO0)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .duty_data(dd[0]), .duty_valid(dv[0]), .period_us(pu[0]),
    .period_valid(pv[0]), .no_edge(ne[0]), .led_bar(lb[0])
  );

  pwm_duty_capture #(
    .TICKS_PER_US(T1), .WINDOW(W1), .PERIOD_TIMEOUT(TO1)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .pwm_in(pwm_in),
    .duty_data(dd[1]), .duty_valid(dv[1]), .period_us(pu[1]),
    .period_valid(pv[1]), .no_edge(ne[1]), .led_bar(lb[1])
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: k counts clocks since reset release; h1/h2 hold the
  // last two pwm_in samples; sp is the synchronized level seen last cycle.
  int k, start;
  bit h1, h2, sp, have_edge;
  int wsum [2], e_duty [2], e_per [2];
  bit e_dv [2], e_pv [2], e_ne [2];
  int e_led [2];

  function automatic int bar(input int duty, input int w);
    int step, n;
    step = w / 8;
    n = (step == 0) ? 8 : duty / step;
    if (n > 8) n = 8;
    return (1 << n) - 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic model_reset();
    k = 0; start = 0; h1 = 0; h2 = 0; sp = 0; have_edge = 0;
    for (int i = 0; i < 2; i++) begin
      wsum[i] = 0; e_duty[i] = 0; e_per[i] = 0;
      e_dv[i] = 0; e_pv[i] = 0; e_ne[i] = 0; e_led[i] = 0;
    end
  endtask

  task automatic model_inst(input int i, input int t, input int w, input int to,
                            input bit s, input bit rise);
    int cb, ca;
    e_dv[i] = 0;
    e_pv[i] = 0;
    e_led[i] = bar(e_duty[i], w);
    if (k % t == t - 1) begin
      wsum[i] += int'(s);
      if ((k / t) % w == w - 1) begin
        e_duty[i] = wsum[i];
        wsum[i] = 0;
        e_dv[i] = 1;
      end
    end
    // Ticks counted since the last edge (or reset), saturating at the timeout.
    cb = k / t - start / t;
    if (cb > to) cb = to;
    if (rise) begin
      if (have_edge && cb < to) begin
        e_per[i] = cb;
        e_pv[i] = 1;
      end else begin
        e_ne[i] = 0;
      end
    end else begin
      ca = (k + 1) / t - start / t;
      if (ca >= to) begin
        e_ne[i] = 1;
        e_per[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d duty_data", i), 32'(dd[i]), e_duty[i]);
      chk($sformatf("dut%0d duty_valid", i), 32'(dv[i]), 32'(e_dv[i]));
      chk($sformatf("dut%0d period_us", i), 32'(pu[i]), e_per[i]);
      chk($sformatf("dut%0d period_valid", i), 32'(pv[i]), 32'(e_pv[i]));
      chk($sformatf("dut%0d no_edge", i), 32'(ne[i]), 32'(e_ne[i]));
      chk($sformatf("dut%0d led_bar", i), 32'(lb[i]), e_led[i]);
    end
  endtask

  // Drive one input level for one clock and check all outputs afterwards.
  task automatic step(input bit v);
    bit s, rise;
    pwm_in = v;
    @(posedge clk);
    s = h2;
    rise = s && !sp;
    model_inst(0, T0, W0, TO0, s, rise);
    model_inst(1, T1, W1, TO1, s, rise);
    if (rise) begin
      have_edge = 1;
      start = k + 1;
    end
    sp = s; h2 = h1; h1 = v; k++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("dut%0d reset duty_data", i), 32'(dd[i]), 0);
      chk($sformatf("dut%0d reset duty_valid", i), 32'(dv[i]), 0);
      chk($sformatf("dut%0d reset period_us", i), 32'(pu[i]), 0);
      chk($sformatf("dut%0d reset period_valid", i), 32'(pv[i]), 0);
      chk($sformatf("dut%0d reset no_edge", i), 32'(ne[i]), 0);
      chk($sformatf("dut%0d reset led_bar", i), 32'(lb[i]), 0);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic stream(input int period, input int high, input int n);
    for (int c = 0; c < n; c++) step((c % period) < high);
  endtask

  initial begin
    int per, hi;
    #1;
    // Held high: full-scale duty, timeout, never a period measurement.
    do_reset();
    stream(1, 1, 2100);
    // 25% duty, 100-cycle period.
    do_reset();
    stream(100, 25, 3000);
    // Held low.
    do_reset();
    stream(1, 0, 2100);
    // Edges stop, then restart.
    do_reset();
    stream(100, 25, 500);
    stream(1, 0, 2100);
    stream(100, 25, 300);
    // Asynchronous reset mid-window, released and run past the next window.
    stream(100, 25, 200);
    #2;
    do_reset();
    stream(100, 25, 1100);
    // Randomized PWM segments and random bit noise.
    for (int seg = 0; seg < 4; seg++) begin
      per = $urandom_range(20, 400);
      hi = $urandom_range(0, per);
      stream(per, hi, $urandom_range(800, 2000));
    end
    for (int c = 0; c < 500; c++) step(1'($urandom_range(0, 1)));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
